// File: rtl/dcache_flush_ctrl.sv
// Data-cache flush controller.
// Write-back mode copies every cache word to memory at base + index*(DATABITS/8).
// Fill mode reads the same memory range and writes it into the cache.
//
// Memory handshake: mem_req is the valid and mem_ack is the ready. A request
// completes on each rising edge where both are high. While mem_req is high and
// mem_ack is low, mem_we, mem_addr and mem_wdata hold their values. mem_ack
// has no effect while mem_req is low.
module dcache_flush_ctrl #(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 5,
    parameter int MEMSIZE     = 2**ADDRBITS,
    parameter int MEMADDRBITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_start,
    input  logic                   flush_fill,
    input  logic [MEMADDRBITS-1:0] flush_base,
    output logic                   flush_busy,
    output logic                   flush_done,
    output logic                   flush_mode,
    output logic [ADDRBITS-1:0]    flush_addr,
    output logic [DATABITS-1:0]    flush_in,
    output logic                   flush_we,
    input  logic [DATABITS-1:0]    flush_rd,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [MEMADDRBITS-1:0] mem_addr,
    output logic [DATABITS-1:0]    mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATABITS-1:0]    mem_rdata
);

    localparam logic [MEMADDRBITS-1:0] WORD_BYTES = MEMADDRBITS'(DATABITS / 8);
    localparam logic [ADDRBITS-1:0]    LAST_INDEX = ADDRBITS'(MEMSIZE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_LAT  = 3'd2,
        WB_REQ  = 3'd3,
        FL_REQ  = 3'd4,
        FL_WR   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDRBITS-1:0]     index;
    logic [MEMADDRBITS-1:0]  base;
    logic [DATABITS-1:0]     buffer;
    logic [MEMADDRBITS-1:0]  word_addr;
    logic                    last_word;

    // Index is zero-extended before scaling; the sum wraps at the address width.
    assign word_addr = base + MEMADDRBITS'(index) * WORD_BYTES;
    assign last_word = (index == LAST_INDEX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Moore outputs; the controller owns the RAM outside IDLE.
    always_comb begin
        state_next = state;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        flush_mode = 1'b0;
        flush_addr = '0;
        flush_in   = '0;
        flush_we   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state != IDLE) begin
            flush_busy = 1'b1;
            flush_mode = 1'b1;
        end
        case (state)
            IDLE: begin
                if (flush_start) begin
                    state_next = flush_fill ? FL_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                flush_addr = index;
                state_next = RD_LAT;
            end
            RD_LAT: begin
                flush_addr = index;
                state_next = WB_REQ;
            end
            WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = buffer;
                if (mem_ack) begin
                    state_next = last_word ? DONE : RD_ADDR;
                end
            end
            FL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (mem_ack) begin
                    state_next = FL_WR;
                end
            end
            FL_WR: begin
                flush_addr = index;
                flush_in   = buffer;
                flush_we   = 1'b1;
                state_next = last_word ? DONE : FL_REQ;
            end
            DONE: begin
                flush_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: base latch, word index and the one-word data buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            index  <= '0;
            base   <= '0;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_start) begin
                        base  <= flush_base;
                        index <= '0;
                    end
                end
                RD_LAT: begin
                    buffer <= flush_rd;
                end
                WB_REQ: begin
                    if (mem_ack && !last_word) begin
                        index <= index + ADDRBITS'(1);
                    end
                end
                FL_REQ: begin
                    if (mem_ack) begin
                        buffer <= mem_rdata;
                    end
                end
                FL_WR: begin
                    if (!last_word) begin
                        index <= index + ADDRBITS'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with a synchronous-read memblock model
// and a memory responder with configurable ack delay.
module tb_dcache_flush_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int N   = 32;
    localparam int MAW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_start;
    logic            flush_fill;
    logic [MAW-1:0]  flush_base;
    logic            flush_busy;
    logic            flush_done;
    logic            flush_mode;
    logic [AW-1:0]   flush_addr;
    logic [DW-1:0]   flush_in;
    logic            flush_we;
    logic [DW-1:0]   flush_rd;
    logic            mem_req;
    logic            mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    always #5 clk = ~clk;

    dcache_flush_ctrl #(
        .DATABITS(DW), .ADDRBITS(AW), .MEMSIZE(N), .MEMADDRBITS(MAW)
    ) dut (
        .clk(clk), .reset(reset),
        .flush_start(flush_start), .flush_fill(flush_fill), .flush_base(flush_base),
        .flush_busy(flush_busy), .flush_done(flush_done), .flush_mode(flush_mode),
        .flush_addr(flush_addr), .flush_in(flush_in), .flush_we(flush_we),
        .flush_rd(flush_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Memory returns a pattern derived from the requested address.
    assign mem_rdata = 32'hC0DE_0000 + mem_addr;

    logic [106:0] all_out;
    assign all_out = {flush_busy, flush_done, flush_mode, flush_addr, flush_in, flush_we,
                      mem_req, mem_we, mem_addr, mem_wdata};

    int tests = 0;
    int fails = 0;

    // Memblock model.
    logic [DW-1:0] cache [N];
    logic [AW-1:0] p_addr;
    logic          p_we;
    logic [DW-1:0] p_in;

    // Results collected by run_op.
    logic [MAW-1:0] wr_addr_q[$];
    logic [DW-1:0]  wr_data_q[$];
    logic [MAW-1:0] rd_addr_q[$];
    logic [DW-1:0]  exp_q[$];
    int done_cnt, done_cycle, stab_err, we_cnt, busy_err, busy_after;

    // Advance one clock; update the memblock model from last cycle's port values.
    task automatic tick();
        @(posedge clk);
        #1;
        flush_rd = cache[p_addr];
        if (p_we) cache[p_addr] = p_in;
        p_addr = flush_addr;
        p_we   = flush_we;
        p_in   = flush_in;
    endtask

    task automatic preload();
        for (int i = 0; i < N; i++) cache[i] = 32'hA500_0000 + 32'(i);
    endtask

    // Start one operation and run it to DONE plus three idle cycles.
    task automatic run_op(input logic fill, input logic [MAW-1:0] base, input int ack_delay,
                          input int poke_cycle, input logic poke_done, input int max_cycles);
        int n;
        int req_cnt;
        logic [MAW-1:0] h_addr;
        logic           h_we;
        logic [DW-1:0]  h_wdata;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        done_cnt = 0; done_cycle = -1; stab_err = 0; we_cnt = 0; busy_err = 0; busy_after = 0;
        h_addr = '0; h_we = 1'b0; h_wdata = '0;
        flush_start = 1'b1;
        flush_fill  = fill;
        flush_base  = base;
        mem_ack     = (ack_delay == 0);
        tick();
        n = 1;
        flush_start = 1'b0;
        flush_fill  = ~fill;
        flush_base  = base ^ 32'h5A5A_0000;
        req_cnt = 0;
        while (n < max_cycles) begin
            if (done_cycle < 0) begin
                if (flush_busy !== 1'b1 || flush_mode !== 1'b1) busy_err++;
            end else if (flush_busy !== 1'b0 || flush_mode !== 1'b0 || mem_req !== 1'b0) begin
                busy_after++;
            end
            if (ack_delay == 0) mem_ack = 1'b1;
            else mem_ack = (mem_req === 1'b1) && (req_cnt >= ack_delay);
            if (mem_req === 1'b1) begin
                if (req_cnt > 0 && (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata))
                    stab_err++;
                h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                if (mem_ack) begin
                    if (mem_we) begin
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end else begin
                        rd_addr_q.push_back(mem_addr);
                    end
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end
            if (flush_we === 1'b1) we_cnt++;
            if (flush_done === 1'b1) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = n;
            end
            flush_start = (n == poke_cycle) || (poke_done && flush_done === 1'b1);
            if (flush_start) begin
                flush_fill = ~fill;
                flush_base = 32'h0000_9000;
            end
            if (done_cycle >= 0 && n >= done_cycle + 3) break;
            tick();
            n++;
        end
        flush_start = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_start = 1'b0; flush_fill = 1'b0; flush_base = '0; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (all_out !== '0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d outputs got %h exp 0", i, all_out);
            end
        end
        tests++;
        if (flush_mode !== 1'b0) begin
            fails++;
            $display("FAIL reset_mode got %b exp 0", flush_mode);
        end
    endtask

    task automatic check_wb(input string name, input logic [MAW-1:0] base, input int exp_done_cycle);
        tests++;
        if (wr_addr_q.size() != N || rd_addr_q.size() != 0) begin
            fails++;
            $display("FAIL %s_count writes %0d reads %0d exp %0d/0", name, wr_addr_q.size(),
                     rd_addr_q.size(), N);
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(32'hA500_0000 + 32'(i));
        for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
            logic [MAW-1:0] ea;
            logic [DW-1:0]  ed;
            ea = base + 32'(4 * i);
            ed = exp_q.pop_front();
            tests++;
            if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) begin
                fails++;
                $display("FAIL %s_word[%0d] got %h/%h exp %h/%h", name, i, wr_addr_q[i],
                         wr_data_q[i], ea, ed);
            end
        end
        tests++;
        if (done_cnt != 1 || done_cycle != exp_done_cycle) begin
            fails++;
            $display("FAIL %s_done count %0d cycle %0d exp 1/%0d", name, done_cnt, done_cycle,
                     exp_done_cycle);
        end
        tests++;
        if (busy_err != 0 || busy_after != 0 || we_cnt != 0 || stab_err != 0) begin
            fails++;
            $display("FAIL %s_ctrl busy_err %0d busy_after %0d we %0d stab %0d exp 0/0/0/0",
                     name, busy_err, busy_after, we_cnt, stab_err);
        end
    endtask

    task automatic test_writeback();
        preload();
        run_op(1'b0, 32'h0000_1000, 0, -1, 1'b0, 200);
        check_wb("wb", 32'h0000_1000, 97);
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) cache[i] = '0;
        run_op(1'b1, 32'h0000_2000, 3, -1, 1'b0, 400);
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] ed;
            ed = 32'hC0DE_2000 + 32'(4 * i);
            tests++;
            if (cache[i] !== ed) begin
                fails++;
                $display("FAIL fill_word[%0d] got %h exp %h", i, cache[i], ed);
            end
        end
        tests++;
        if (we_cnt != N || rd_addr_q.size() != N || wr_addr_q.size() != 0) begin
            fails++;
            $display("FAIL fill_count we %0d reads %0d writes %0d exp %0d/%0d/0", we_cnt,
                     rd_addr_q.size(), wr_addr_q.size(), N, N);
        end
        tests++;
        if (stab_err != 0 || busy_err != 0 || busy_after != 0) begin
            fails++;
            $display("FAIL fill_stable stab %0d busy_err %0d busy_after %0d exp 0/0/0",
                     stab_err, busy_err, busy_after);
        end
        tests++;
        if (done_cnt != 1 || done_cycle != 161) begin
            fails++;
            $display("FAIL fill_done count %0d cycle %0d exp 1/161", done_cnt, done_cycle);
        end
    endtask

    task automatic test_wrap();
        preload();
        run_op(1'b0, 32'hFFFF_FFF0, 0, -1, 1'b0, 200);
        check_wb("wrap", 32'hFFFF_FFF0, 97);
        tests++;
        if (wr_addr_q.size() == N && (wr_addr_q[3] !== 32'hFFFF_FFFC || wr_addr_q[4] !== 32'h0
                                      || wr_addr_q[N-1] !== 32'h0000_006C)) begin
            fails++;
            $display("FAIL wrap_edges got %h %h %h exp fffffffc 00000000 0000006c",
                     wr_addr_q[3], wr_addr_q[4], wr_addr_q[N-1]);
        end
    endtask

    task automatic test_ignore_start();
        preload();
        run_op(1'b0, 32'h0000_3000, 0, 40, 1'b1, 200);
        check_wb("ignore", 32'h0000_3000, 97);
    endtask

    task automatic test_reset_mid();
        int wb;
        int n;
        int seen_done;
        preload();
        wb = 0; n = 0; seen_done = 0;
        flush_start = 1'b1; flush_fill = 1'b0; flush_base = 32'h0000_4000; mem_ack = 1'b1;
        tick();
        flush_start = 1'b0;
        while (n < 100) begin
            if (mem_req === 1'b1 && mem_we === 1'b1) wb++;
            if (wb == 10) break;
            tick();
            n++;
        end
        tests++;
        if (wb != 10 || mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_reach wb_req seen %0d exp 10", wb);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs got %h exp 0", all_out);
        end
        for (int i = 0; i < 4; i++) begin
            if (flush_done === 1'b1 || flush_busy !== 1'b0) seen_done++;
            tick();
        end
        tests++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL rstmid_quiet got %0d busy/done cycles exp 0", seen_done);
        end
        run_op(1'b0, 32'h0000_5000, 0, -1, 1'b0, 200);
        check_wb("restart", 32'h0000_5000, 97);
    endtask

    initial begin
        p_addr = '0; p_we = 1'b0; p_in = '0; flush_rd = '0;
        for (int i = 0; i < N; i++) cache[i] = '0;
        test_reset();
        test_writeback();
        test_fill();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
